// File: rtl/branch_pc_unit.sv
// Branch / PC unit: sequential fetch-address generation with conditional and
// unconditional branch redirection.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   stall              freeze sequential fetch (RUN state only)
//   br_req             decoded conditional branch; cond_ok arrives next cycle
//   br_uncond          decoded unconditional branch (priority over br_req)
//   br_pc, br_offset   branch address and signed halfword offset
//   cond_ok            registered condition result, sampled in WAIT_COND only
//   pc, fetch_valid    current fetch address and its validity
//   flush              one-cycle pulse coinciding with pc first showing target
//   busy               high while not in RUN
//   taken_cnt          wrapping count of taken branches
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_req,
    input  logic        br_uncond,
    input  logic [31:0] br_pc,
    input  logic [10:0] br_offset,
    input  logic        cond_ok,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        busy,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        StRun,
        StWaitCond,
        StRedirect
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] target_q, target_d;
    logic [31:0] fall_q, fall_d;

    logic [31:0] br_target;

    // Halfword offset scaled to bytes, relative to br_pc + 4; bit 0 cleared.
    assign br_target = (br_pc + 32'd4 + {{20{br_offset[10]}}, br_offset, 1'b0}) & ~32'd1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = 1'b0;
        taken_cnt_d = taken_cnt_q;
        target_d    = target_q;
        fall_d      = fall_q;
        unique case (state_q)
            StRun: begin
                if (!stall) begin
                    if (br_uncond || br_req) begin
                        // pc holds while the branch resolves
                        target_d = br_target;
                        fall_d   = br_pc + 32'd2;
                        state_d  = br_uncond ? StRedirect : StWaitCond;
                    end else begin
                        pc_d = pc_q + 32'd2;
                    end
                end
            end
            StWaitCond: begin
                state_d = StRun;
                if (cond_ok) begin
                    pc_d        = target_q;
                    flush_d     = 1'b1;
                    taken_cnt_d = taken_cnt_q + 16'd1;
                end else begin
                    pc_d = fall_q;
                end
            end
            StRedirect: begin
                state_d     = StRun;
                pc_d        = target_q;
                flush_d     = 1'b1;
                taken_cnt_d = taken_cnt_q + 16'd1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            taken_cnt_q <= 16'd0;
            target_q    <= 32'd0;
            fall_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            taken_cnt_q <= taken_cnt_d;
            target_q    <= target_d;
            fall_q      <= fall_d;
        end
    end

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign taken_cnt   = taken_cnt_q;
    assign busy        = (state_q != StRun);
    assign fetch_valid = (state_q == StRun) && !rst;

endmodule
